spi_slave16: RTL and testbench

16-bit SPI responder for the Segway design: the slave-side counterpart of the 16-bit SPI master, used in bench models of the inertial sensor and A2D, and in any on-chip block addressed over SPI. Mode 3: SCLK idles high, MOSI is sampled on SCLK rise, and MISO is updated on SCLK fall. SCLK, SS_n and MOSI are oversampled on the 50 MHz system clock, so the block needs no second clock domain. It presents one 16-bit word per frame on `rx_data` and shifts out `tx_data`, MSB first.

---
 rtl/spi_slave16.sv | 97 +++++++++
 tb/tb_spi_slave16.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave16.sv
// spi_slave16: 16-bit SPI mode-3 responder, oversampled on the system clock.
// SCLK, SS_n and MOSI are synchronized into clk; MOSI is captured on SCLK rise
// and MISO advances on SCLK fall. One word per SS_n-low frame.
module spi_slave16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        frm_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [4:0] FRAME_BITS = 5'd16;

  state_t      state;
  logic        sclk_ff1, sclk_ff2, sclk_ff3;
  logic        ss_ff1, ss_ff2, ss_ff3;
  logic        mosi_ff1, mosi_ff2, mosi_ff3;
  logic [15:0] rx_shft;
  logic [15:0] tx_shft;
  logic [4:0]  bit_cnt;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Three-flop synchronizers; ff3 exists so edges can be detected on ff2/ff3.
  // SCLK resets to its idle-high level so reset release shows no false edge.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here -- tested inside the clocked block, not in the sensitivity list.
    if (!rst_n) begin
      {sclk_ff1, sclk_ff2, sclk_ff3} <= 3'b111;
      {ss_ff1, ss_ff2, ss_ff3}       <= 3'b000;
      {mosi_ff1, mosi_ff2, mosi_ff3} <= 3'b000;
    end else begin
      {sclk_ff1, sclk_ff2, sclk_ff3} <= {SCLK, sclk_ff1, sclk_ff2};
      {ss_ff1, ss_ff2, ss_ff3}       <= {SS_n, ss_ff1, ss_ff2};
      {mosi_ff1, mosi_ff2, mosi_ff3} <= {MOSI, mosi_ff1, mosi_ff2};
    end
  end

  assign sclk_rise = sclk_ff2 & ~sclk_ff3;
  assign sclk_fall = ~sclk_ff2 & sclk_ff3;
  assign ss_rise   = ss_ff2 & ~ss_ff3;
  assign ss_fall   = ~ss_ff2 & ss_ff3;

  // Frame FSM with shifters, bit counter and registered rdy/frm_err pulses.
  // SS_n edges take priority; an SCLK edge in the same cycle is dropped.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      rx_shft <= '0;
      tx_shft <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      if (ss_fall) begin
        // Start of frame, or a restart if a stray fall arrives while active.
        state   <= ACTIVE;
        tx_shft <= tx_data;
        bit_cnt <= '0;
      end else if (ss_rise) begin
        // A rise while idle (e.g. SS_n high at reset release) is ignored.
        if (state == ACTIVE) begin
          state <= IDLE;
          if (bit_cnt == FRAME_BITS) begin
            rx_data <= rx_shft;
            rdy     <= 1'b1;
          end else begin
            frm_err <= 1'b1;
          end
        end
      end else if (state == ACTIVE) begin
        if (sclk_rise && (bit_cnt < FRAME_BITS)) begin
          rx_shft <= {rx_shft[14:0], mosi_ff3};
          bit_cnt <= bit_cnt + 5'd1;
        end else if (sclk_fall && (bit_cnt != 5'd0) && (bit_cnt < FRAME_BITS)) begin
          // The fall at bit_cnt 0 is the master's front porch: MISO already
          // shows tx_data[15], so it must not shift.
          tx_shft <= {tx_shft[14:0], 1'b0};
        end
      end
    end
  end

  assign MISO = tx_shft[15];

endmodule

// File: tb/tb_spi_slave16.sv
// tb_spi_slave16: mode-3 SPI master model driving spi_slave16 at SCLK = clk/32.
// Table of frames plus hand-written reset sequences; received words are
// scoreboarded against rdy pulses.
module tb_spi_slave16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic [15:0] tx_data = '0;
  logic        MISO;
  logic [15:0] rx_data;
  logic        rdy;
  logic        frm_err;

  int checks  = 0;
  int errors  = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [31:0] mosi;     // bits sent MSB first from bit 31
    logic [15:0] tx;
    int          nbits;
    int          exp_rdy;
    int          exp_err;
    logic [15:0] exp_rx;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  spi_slave16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle SCLK for n bits; MOSI changes on fall, MISO sampled on rise.
  task automatic sclk_bits(input logic [31:0] bits, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = bits[31-i];
      wait_clks(16);
      SCLK = 1'b1;
      if (i < 16) rd = {rd[14:0], MISO};
      wait_clks(16);
    end
  endtask

  task automatic frame(input logic [31:0] bits, input logic [15:0] tx, input int n,
                       output logic [15:0] rd);
    tx_data = tx;
    SS_n = 1'b0;
    wait_clks(16);
    sclk_bits(bits, n, rd);
    wait_clks(8);
    SS_n = 1'b1;
    wait_clks(12);
  endtask

  // Scoreboard: every rdy pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      if (sb_q.size() == 0) check("sb_unexpected_rdy", 32'd1, 32'd0);
      else check("sb_rx_data", {16'h0, rx_data}, {16'h0, sb_q.pop_front()});
    end
    if (frm_err) err_cnt++;
  end

  initial begin
    int r0, e0;
    logic [15:0] rd;

    //           mosi                   tx        n  rdy err exp_rx    chk  exp_rd
    vecs[0] = '{32'hA5C3_0000,         16'h3C5A, 16, 1, 0, 16'hA5C3, 1'b1, 16'h3C5A};
    vecs[1] = '{32'h0001_0000,         16'h1234, 16, 1, 0, 16'h0001, 1'b1, 16'h1234};
    vecs[2] = '{32'hFFFF_0000,         16'hFEDC, 16, 1, 0, 16'hFFFF, 1'b1, 16'hFEDC};
    vecs[3] = '{32'h8000_0000,         16'h0000, 16, 1, 0, 16'h8000, 1'b1, 16'h0000};
    vecs[4] = '{32'h5555_0000,         16'hAAAA,  9, 0, 1, 16'h8000, 1'b0, 16'h0000};
    vecs[5] = '{32'h1357_0000,         16'h2468, 16, 1, 0, 16'h1357, 1'b1, 16'h2468};
    vecs[6] = '{32'hBEEF_C000,         16'h1234, 18, 1, 0, 16'hBEEF, 1'b1, 16'h1234};

    // Reset with SS_n high: the rise seen at release must be ignored.
    wait_clks(4);
    check("reset_rx_data", {16'h0, rx_data}, 32'h0);
    check("reset_miso", {31'h0, MISO}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_frm_err", {31'h0, frm_err}, 32'h0);
    rst_n = 1'b1;
    wait_clks(10);
    check("release_pulses", rdy_cnt + err_cnt, 32'd0);

    for (int i = 0; i < 7; i++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      if (vecs[i].exp_rdy != 0) sb_q.push_back(vecs[i].exp_rx);
      frame(vecs[i].mosi, vecs[i].tx, vecs[i].nbits, rd);
      check($sformatf("v%0d_rdy_cnt", i), rdy_cnt - r0, vecs[i].exp_rdy);
      check($sformatf("v%0d_frm_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d_rx_data", i), {16'h0, rx_data}, {16'h0, vecs[i].exp_rx});
      if (vecs[i].chk_rd) check($sformatf("v%0d_rd_data", i), {16'h0, rd}, {16'h0, vecs[i].exp_rd});
      if (vecs[i].nbits > 16) check($sformatf("v%0d_miso_tail", i), {31'h0, MISO}, 32'h0);
    end

    // Reset mid-frame: 8 bits in, reset for 2 clks, then SS_n rises in IDLE.
    r0 = rdy_cnt;
    e0 = err_cnt;
    tx_data = 16'hCAFE;
    SS_n = 1'b0;
    wait_clks(16);
    sclk_bits(32'hF0F0_0000, 8, rd);
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(1);
    check("midrst_rx_data", {16'h0, rx_data}, 32'h0);
    check("midrst_miso", {31'h0, MISO}, 32'h0);
    wait_clks(8);
    SS_n = 1'b1;
    wait_clks(12);
    check("midrst_rdy", rdy_cnt - r0, 32'd0);
    check("midrst_frm_err", err_cnt - e0, 32'd0);
    sb_q.push_back(16'h7E81);
    frame(32'h7E81_0000, 16'h0F0F, 16, rd);
    check("midrst_next_rdy", rdy_cnt - r0, 32'd1);
    check("midrst_next_rx", {16'h0, rx_data}, 32'h7E81);
    check("midrst_next_rd", {16'h0, rd}, 32'h0F0F);

    // Reset released with SS_n low and SCLK toggling: no frame may start.
    r0 = rdy_cnt;
    e0 = err_cnt;
    tx_data = 16'h9999;
    SS_n = 1'b0;
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    sclk_bits(32'hFFFF_FFFF, 10, rd);
    wait_clks(8);
    check("sslow_pulses", (rdy_cnt - r0) + (err_cnt - e0), 32'd0);
    check("sslow_rx_data", {16'h0, rx_data}, 32'h0);
    check("sslow_miso", {31'h0, MISO}, 32'h0);
    SS_n = 1'b1;
    wait_clks(12);
    check("sslow_rise_pulses", (rdy_cnt - r0) + (err_cnt - e0), 32'd0);
    sb_q.push_back(16'h4B2D);
    frame(32'h4B2D_0000, 16'hD2B4, 16, rd);
    check("sslow_next_rdy", rdy_cnt - r0, 32'd1);
    check("sslow_next_err", err_cnt - e0, 32'd0);
    check("sslow_next_rx", {16'h0, rx_data}, 32'h4B2D);
    check("sslow_next_rd", {16'h0, rd}, 32'hD2B4);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
